// File: rtl/axi_rd_pkg.sv
// Shared encodings, sizes and types for the AXI-style 2D read engine.
package axi_rd_pkg;

    localparam int unsigned ADDR_W    = 10;
    localparam int unsigned DATA_W    = 64;
    localparam int unsigned BUF_DEPTH = 2;
    localparam int unsigned BEAT_W    = DATA_W + 3;

    localparam logic [1:0] BURST_FIXED = 2'b00;
    localparam logic [1:0] BURST_INCR  = 2'b01;
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;
    localparam logic [2:0] SIZE_64     = 3'd3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_DRAIN
    } rd_state_e;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic [1:0]        resp;
        logic              last;
    } beat_t;

    function automatic logic is_err_req(input logic [2:0] size, input logic [1:0] burst);
        return ((burst != BURST_FIXED) && (burst != BURST_INCR)) || (size != SIZE_64);
    endfunction

endpackage

// File: rtl/rd_beat_fifo.sv
// Two-entry FIFO for read beats (data, resp, last); push and pop may coincide.
module rd_beat_fifo
    import axi_rd_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [BEAT_W-1:0] push_data,
    input  logic              pop,
    output logic [BEAT_W-1:0] head,
    output logic              full,
    output logic              empty
);

    logic [BEAT_W-1:0] mem_q [BUF_DEPTH];
    logic [BEAT_W-1:0] mem_d [BUF_DEPTH];
    logic              wr_ptr_q, wr_ptr_d;
    logic              rd_ptr_q, rd_ptr_d;
    logic [1:0]        count_q, count_d;
    logic              do_push, do_pop;

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        do_pop   = pop && (count_q != 2'd0);
        // A pop in the same cycle frees the slot the push lands in.
        do_push  = push && ((count_q != 2'(BUF_DEPTH)) || do_pop);
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (do_pop) begin
            rd_ptr_d = ~rd_ptr_q;
        end
        count_d = count_q + 2'(do_push) - 2'(do_pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned i = 0; i < BUF_DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= 2'd0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_comb begin
        head  = mem_q[rd_ptr_q];
        full  = (count_q == 2'(BUF_DEPTH));
        empty = (count_q == 2'd0);
    end

endmodule

// File: rtl/axi_rd_engine.sv
// 2D strided read engine: accepts one request, issues rows x beats memory reads
// under a 2-credit rule and returns beats through a 2-entry buffer.
module axi_rd_engine
    import axi_rd_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  lsu_axi_arid,
    input  logic [9:0]  lsu_axi_araddr,
    input  logic [7:0]  lsu_axi_arlen,
    input  logic [2:0]  lsu_axi_arsize,
    input  logic [1:0]  lsu_axi_arburst,
    input  logic [2:0]  lsu_axi_arstr,
    input  logic [7:0]  lsu_axi_arnum,
    input  logic        lsu_axi_arvld,
    output logic        axi_lsu_arrdy,
    output logic [7:0]  axi_lsu_rid,
    output logic [63:0] axi_lsu_rdata,
    output logic [1:0]  axi_lsu_rresp,
    output logic        axi_lsu_rlast,
    output logic        axi_lsu_rvld,
    input  logic        lsu_axi_rrdy,
    output logic        mem_rd_en,
    output logic [9:0]  mem_rd_addr,
    input  logic [63:0] mem_rd_data
);

    rd_state_e         state_q, state_d;
    logic [7:0]        arid_q, arid_d;
    logic [7:0]        arlen_q, arlen_d;
    logic [2:0]        arstr_q, arstr_d;
    logic [1:0]        burst_q, burst_d;
    logic              err_q, err_d;
    logic [7:0]        beat_q, beat_d;
    logic [ADDR_W-1:0] row_base_q, row_base_d;
    logic [16:0]       left_q, left_d;
    logic              infl_q, infl_d;
    logic              infl_err_q, infl_err_d;
    logic              infl_last_q, infl_last_d;

    logic              accept, issue, pop, last_issue;
    logic [2:0]        occ, used;
    logic [ADDR_W-1:0] beat_addr;
    logic [16:0]       total;
    beat_t             push_beat, head_beat;
    logic              fifo_full, fifo_empty;

    always_comb begin
        state_d     = state_q;
        arid_d      = arid_q;
        arlen_d     = arlen_q;
        arstr_d     = arstr_q;
        burst_d     = burst_q;
        err_d       = err_q;
        beat_d      = beat_q;
        row_base_d  = row_base_q;
        left_d      = left_q;

        accept     = lsu_axi_arvld && (state_q == ST_IDLE);
        pop        = !fifo_empty && lsu_axi_rrdy;
        occ        = fifo_full ? 3'd2 : (fifo_empty ? 3'd0 : 3'd1);
        // Credit counts a beat leaving this cycle, keeping 1 beat/cycle sustainable.
        used       = occ + 3'(infl_q) - 3'(pop);
        issue      = (state_q == ST_ISSUE) && (used < 3'd2) && !rst;
        last_issue = (left_q == 17'd0);
        beat_addr  = row_base_q + ((burst_q == BURST_INCR) ? ADDR_W'(beat_q) : '0);
        total      = (17'(lsu_axi_arnum) + 17'd1) * (17'(lsu_axi_arlen) + 17'd1);

        infl_d      = issue;
        infl_err_d  = err_q;
        infl_last_d = last_issue;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    state_d    = ST_ISSUE;
                    arid_d     = lsu_axi_arid;
                    arlen_d    = lsu_axi_arlen;
                    arstr_d    = lsu_axi_arstr;
                    burst_d    = lsu_axi_arburst;
                    err_d      = is_err_req(lsu_axi_arsize, lsu_axi_arburst);
                    beat_d     = 8'd0;
                    row_base_d = lsu_axi_araddr;
                    left_d     = total - 17'd1;
                end
            end
            ST_ISSUE: begin
                if (issue) begin
                    left_d = left_q - 17'd1;
                    if (beat_q == arlen_q) begin
                        beat_d     = 8'd0;
                        row_base_d = row_base_q + (ADDR_W'(1) << arstr_q);
                    end else begin
                        beat_d = beat_q + 8'd1;
                    end
                    if (last_issue) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_DRAIN: begin
                if (pop && head_beat.last) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        push_beat.data = infl_err_q ? '0 : mem_rd_data;
        push_beat.resp = infl_err_q ? RESP_SLVERR : RESP_OKAY;
        push_beat.last = infl_last_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            arid_q      <= '0;
            arlen_q     <= '0;
            arstr_q     <= '0;
            burst_q     <= '0;
            err_q       <= 1'b0;
            beat_q      <= '0;
            row_base_q  <= '0;
            left_q      <= '0;
            infl_q      <= 1'b0;
            infl_err_q  <= 1'b0;
            infl_last_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            arid_q      <= arid_d;
            arlen_q     <= arlen_d;
            arstr_q     <= arstr_d;
            burst_q     <= burst_d;
            err_q       <= err_d;
            beat_q      <= beat_d;
            row_base_q  <= row_base_d;
            left_q      <= left_d;
            infl_q      <= infl_d;
            infl_err_q  <= infl_err_d;
            infl_last_q <= infl_last_d;
        end
    end

    rd_beat_fifo u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (infl_q),
        .push_data (push_beat),
        .pop       (pop),
        .head      (head_beat),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        axi_lsu_arrdy = (state_q == ST_IDLE);
        axi_lsu_rvld  = !fifo_empty;
        axi_lsu_rid   = arid_q;
        axi_lsu_rdata = fifo_empty ? '0 : head_beat.data;
        axi_lsu_rresp = fifo_empty ? RESP_OKAY : head_beat.resp;
        axi_lsu_rlast = !fifo_empty && head_beat.last;
        mem_rd_en     = issue && !err_q;
        mem_rd_addr   = mem_rd_en ? beat_addr : '0;
    end

endmodule

// File: tb/tb_axi_rd_engine.sv
// Directed bench for axi_rd_engine with a one-cycle-latency memory model.
module tb_axi_rd_engine;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  lsu_axi_arid;
    logic [9:0]  lsu_axi_araddr;
    logic [7:0]  lsu_axi_arlen;
    logic [2:0]  lsu_axi_arsize;
    logic [1:0]  lsu_axi_arburst;
    logic [2:0]  lsu_axi_arstr;
    logic [7:0]  lsu_axi_arnum;
    logic        lsu_axi_arvld;
    logic        axi_lsu_arrdy;
    logic [7:0]  axi_lsu_rid;
    logic [63:0] axi_lsu_rdata;
    logic [1:0]  axi_lsu_rresp;
    logic        axi_lsu_rlast;
    logic        axi_lsu_rvld;
    logic        lsu_axi_rrdy;
    logic        mem_rd_en;
    logic [9:0]  mem_rd_addr;
    logic [63:0] mem_rd_data;

    int n_tests = 0;
    int n_fail  = 0;

    logic [9:0]  got_addr[$];
    logic [63:0] got_data[$];
    logic [1:0]  got_resp[$];
    logic        got_last[$];
    logic [7:0]  got_id[$];
    logic [9:0]  exp_addr[$];
    int          first_iter, last_iter, max_out, stall_bad, run_mode;
    logic        done;

    always #5 clk = ~clk;

    axi_rd_engine dut (
        .clk             (clk),
        .rst             (rst),
        .lsu_axi_arid    (lsu_axi_arid),
        .lsu_axi_araddr  (lsu_axi_araddr),
        .lsu_axi_arlen   (lsu_axi_arlen),
        .lsu_axi_arsize  (lsu_axi_arsize),
        .lsu_axi_arburst (lsu_axi_arburst),
        .lsu_axi_arstr   (lsu_axi_arstr),
        .lsu_axi_arnum   (lsu_axi_arnum),
        .lsu_axi_arvld   (lsu_axi_arvld),
        .axi_lsu_arrdy   (axi_lsu_arrdy),
        .axi_lsu_rid     (axi_lsu_rid),
        .axi_lsu_rdata   (axi_lsu_rdata),
        .axi_lsu_rresp   (axi_lsu_rresp),
        .axi_lsu_rlast   (axi_lsu_rlast),
        .axi_lsu_rvld    (axi_lsu_rvld),
        .lsu_axi_rrdy    (lsu_axi_rrdy),
        .mem_rd_en       (mem_rd_en),
        .mem_rd_addr     (mem_rd_addr),
        .mem_rd_data     (mem_rd_data)
    );

    function automatic logic [63:0] memf(input logic [9:0] a);
        return {32'hC0DE_F00D, 22'd0, a};
    endfunction

    always @(posedge clk) begin
        mem_rd_data <= mem_rd_en ? memf(mem_rd_addr) : 64'hDEAD_BEEF_DEAD_BEEF;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic pat(input int mode, input int it);
        if (mode == 0) return 1'b1;
        return (it % 4 == 0) || (it % 4 == 3);
    endfunction

    task automatic run_req(input logic [7:0] id, input logic [9:0] addr, input logic [7:0] len,
                           input logic [7:0] num, input logic [2:0] str, input logic [1:0] burst,
                           input logic [2:0] size, input int mode);
        int          issued, popped;
        logic        stalled;
        logic [63:0] hold_data;
        logic [1:0]  hold_resp;
        logic        hold_last;
        got_addr.delete(); got_data.delete(); got_resp.delete();
        got_last.delete(); got_id.delete();
        first_iter = -1; last_iter = -1; max_out = 0; stall_bad = 0; done = 1'b0;
        run_mode = mode; issued = 0; popped = 0; stalled = 1'b0;
        hold_data = '0; hold_resp = '0; hold_last = 1'b0;
        @(posedge clk); #1;
        lsu_axi_arid = id; lsu_axi_araddr = addr; lsu_axi_arlen = len; lsu_axi_arnum = num;
        lsu_axi_arstr = str; lsu_axi_arburst = burst; lsu_axi_arsize = size;
        lsu_axi_arvld = 1'b1; lsu_axi_rrdy = pat(mode, 0);
        @(negedge clk);
        check("arrdy_idle", {63'd0, axi_lsu_arrdy}, 64'd1);
        @(posedge clk); #1;
        lsu_axi_arvld = 1'b0;
        for (int it = 1; it <= 400 && !done; it++) begin
            @(negedge clk);
            if (it == 1) check("arrdy_busy", {63'd0, axi_lsu_arrdy}, 64'd0);
            if (mem_rd_en) begin
                got_addr.push_back(mem_rd_addr);
                issued++;
            end
            if (stalled && !(axi_lsu_rvld && axi_lsu_rdata == hold_data &&
                             axi_lsu_rresp == hold_resp && axi_lsu_rlast == hold_last))
                stall_bad++;
            stalled   = axi_lsu_rvld && !lsu_axi_rrdy;
            hold_data = axi_lsu_rdata; hold_resp = axi_lsu_rresp; hold_last = axi_lsu_rlast;
            if (axi_lsu_rvld && lsu_axi_rrdy) begin
                got_data.push_back(axi_lsu_rdata);
                got_resp.push_back(axi_lsu_rresp);
                got_last.push_back(axi_lsu_rlast);
                got_id.push_back(axi_lsu_rid);
                popped++;
                if (first_iter < 0) first_iter = it;
                last_iter = it;
                if (axi_lsu_rlast) done = 1'b1;
            end
            if (issued - popped > max_out) max_out = issued - popped;
            @(posedge clk); #1;
            lsu_axi_rrdy = pat(mode, it);
        end
    endtask

    task automatic verify(input string tag, input logic [7:0] id, input logic err);
        int n;
        n = exp_addr.size();
        check({tag, "_done"}, {63'd0, done}, 64'd1);
        check({tag, "_nbeats"}, 64'(got_data.size()), 64'(n));
        check({tag, "_nreads"}, 64'(got_addr.size()), err ? 64'd0 : 64'(n));
        if (got_id.size() > 0) check({tag, "_rid"}, 64'(got_id[0]), 64'(id));
        for (int i = 0; i < n; i++) begin
            if (!err && i < got_addr.size())
                check($sformatf("%s_addr%0d", tag, i), 64'(got_addr[i]), 64'(exp_addr[i]));
            if (i < got_data.size()) begin
                check($sformatf("%s_data%0d", tag, i), got_data[i], err ? 64'd0 : memf(exp_addr[i]));
                check($sformatf("%s_resp%0d", tag, i), 64'(got_resp[i]), err ? 64'd2 : 64'd0);
                check($sformatf("%s_last%0d", tag, i), 64'(got_last[i]), (i == n - 1) ? 64'd1 : 64'd0);
            end
        end
        check({tag, "_credit"}, 64'(max_out <= 2), 64'd1);
        check({tag, "_stable"}, 64'(stall_bad), 64'd0);
        if (run_mode == 0) begin
            // first rvld appears two edges after the accepting edge
            check({tag, "_latency"}, 64'(first_iter - 1), 64'd2);
            check({tag, "_thruput"}, 64'(last_iter - first_iter), 64'(n - 1));
        end
    endtask

    initial begin
        int popped;
        rst = 1'b1; lsu_axi_arvld = 1'b0; lsu_axi_rrdy = 1'b1;
        lsu_axi_arid = '0; lsu_axi_araddr = '0; lsu_axi_arlen = '0; lsu_axi_arnum = '0;
        lsu_axi_arstr = '0; lsu_axi_arburst = '0; lsu_axi_arsize = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_arrdy", {63'd0, axi_lsu_arrdy}, 64'd1);
        check("rst_rvld",  {63'd0, axi_lsu_rvld}, 64'd0);
        check("rst_rlast", {63'd0, axi_lsu_rlast}, 64'd0);
        check("rst_rresp", 64'(axi_lsu_rresp), 64'd0);
        check("rst_rid",   64'(axi_lsu_rid), 64'd0);
        check("rst_rdata", axi_lsu_rdata, 64'd0);
        check("rst_memen", {63'd0, mem_rd_en}, 64'd0);
        check("rst_memaddr", 64'(mem_rd_addr), 64'd0);

        run_req(8'h11, 10'h010, 8'd3, 8'd0, 3'd0, 2'b01, 3'd3, 0);
        exp_addr = '{10'h010, 10'h011, 10'h012, 10'h013};
        verify("row", 8'h11, 1'b0);

        run_req(8'h22, 10'h100, 8'd1, 8'd2, 3'd4, 2'b01, 3'd3, 0);
        exp_addr = '{10'h100, 10'h101, 10'h110, 10'h111, 10'h120, 10'h121};
        verify("stride", 8'h22, 1'b0);

        run_req(8'h33, 10'h3FE, 8'd3, 8'd0, 3'd0, 2'b01, 3'd3, 0);
        exp_addr = '{10'h3FE, 10'h3FF, 10'h000, 10'h001};
        verify("wrap", 8'h33, 1'b0);

        run_req(8'h44, 10'h040, 8'd7, 8'd0, 3'd0, 2'b01, 3'd3, 1);
        exp_addr = '{10'h040, 10'h041, 10'h042, 10'h043, 10'h044, 10'h045, 10'h046, 10'h047};
        verify("bp", 8'h44, 1'b0);

        run_req(8'h55, 10'h055, 8'd2, 8'd0, 3'd0, 2'b00, 3'd3, 0);
        exp_addr = '{10'h055, 10'h055, 10'h055};
        verify("fixed", 8'h55, 1'b0);

        run_req(8'h66, 10'h020, 8'd1, 8'd0, 3'd0, 2'b10, 3'd3, 0);
        exp_addr = '{10'h000, 10'h000};
        verify("err_burst", 8'h66, 1'b1);

        run_req(8'h67, 10'h020, 8'd0, 8'd0, 3'd0, 2'b01, 3'd2, 0);
        exp_addr = '{10'h000};
        verify("err_size", 8'h67, 1'b1);

        run_req(8'h77, 10'h080, 8'd1, 8'd0, 3'd0, 2'b01, 3'd3, 0);
        exp_addr = '{10'h080, 10'h081};
        verify("after_err", 8'h77, 1'b0);

        @(posedge clk); #1;
        lsu_axi_arid = 8'h88; lsu_axi_araddr = 10'h200; lsu_axi_arlen = 8'd7; lsu_axi_arnum = 8'd0;
        lsu_axi_arstr = 3'd0; lsu_axi_arburst = 2'b01; lsu_axi_arsize = 3'd3;
        lsu_axi_arvld = 1'b1; lsu_axi_rrdy = 1'b1;
        @(posedge clk); #1;
        lsu_axi_arvld = 1'b0;
        popped = 0;
        for (int it = 0; it < 50 && popped < 2; it++) begin
            @(negedge clk);
            if (axi_lsu_rvld && lsu_axi_rrdy) popped++;
        end
        check("rstmid_progress", 64'(popped), 64'd2);
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("rstmid_rvld",  {63'd0, axi_lsu_rvld}, 64'd0);
        check("rstmid_arrdy", {63'd0, axi_lsu_arrdy}, 64'd1);
        check("rstmid_memen", {63'd0, mem_rd_en}, 64'd0);

        run_req(8'h99, 10'h300, 8'd3, 8'd0, 3'd0, 2'b01, 3'd3, 0);
        exp_addr = '{10'h300, 10'h301, 10'h302, 10'h303};
        verify("post_rst", 8'h99, 1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
